// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (1 start, DATA_WIDTH data bits LSB first, optional parity, 1 stop).
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around the bit centre instead of one centre sample.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic [5:0]            i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_rx_busy
);

  localparam int             BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ZERO = {BCW{1'b0}};
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic f_exp_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    if (odd) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

  logic                  r_sync1;
  logic                  r_sync2;
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            w_edge_nxt;
  logic [5:0]            w_half;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;
  logic                  w_wrap;
  logic                  w_decide;
  logic                  w_tap_mid;
  logic                  w_bit;

  // RX_IN is asynchronous; synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Taps are named by the count value edge_cnt takes on that clock edge.
  always_comb begin
    w_half     = {1'b0, i_prescale[5:1]};
    w_wrap     = (r_edge_cnt == (i_prescale - 6'd1));
    w_edge_nxt = w_wrap ? 6'd0 : (r_edge_cnt + 6'd1);
    w_decide   = (r_state != S_IDLE) && (w_edge_nxt == (w_half + 6'd1));
    w_tap_mid  = (w_edge_nxt == w_half);
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_samp;
  logic       w_tap_lo;

  function automatic logic f_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two early votes are stored; the third is the live synchronised bit at the decision edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_samp <= 2'b11;
    end else begin
      if (w_tap_lo) begin
        r_samp[0] <= r_sync2;
      end
      if (w_tap_mid) begin
        r_samp[1] <= r_sync2;
      end
    end
  end

  always_comb begin
    w_tap_lo = (w_edge_nxt == (w_half - 6'd1));
    w_bit    = f_maj3(r_samp[0], r_samp[1], r_sync2);
  end
`else
  logic r_samp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_samp <= 1'b1;
    end else if (w_tap_mid) begin
      r_samp <= r_sync2;
    end else begin
      r_samp <= r_samp;
    end
  end

  always_comb begin
    w_bit = r_samp;
  end
`endif

  // Stop decision returns straight to IDLE so a start bit right after it is caught.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_decide && w_bit) begin
          w_state_nxt = S_IDLE;
        end else if (w_wrap) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_wrap && (r_bit_cnt == BIT_LAST)) begin
          if (r_par_en) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_decide) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= BIT_ZERO;
      r_shift    <= {DATA_WIDTH{1'b0}};
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        // Parity controls are captured every idle cycle, so the start-detection value is held.
        r_edge_cnt <= 6'd0;
        r_bit_cnt  <= BIT_ZERO;
        r_par_bad  <= 1'b0;
        r_par_en   <= i_par_en;
        r_par_typ  <= i_par_typ;
      end else begin
        r_edge_cnt <= w_edge_nxt;
        if ((r_state == S_DATA) && w_wrap) begin
          r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? BIT_ZERO : (r_bit_cnt + BIT_ONE);
        end
        if (w_decide && (r_state == S_DATA)) begin
          r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
        end
        if (w_decide && (r_state == S_PARITY)) begin
          r_par_bad <= (w_bit != f_exp_parity(r_shift, r_par_typ));
        end
      end
    end
  end

  // Frame outcome is registered on the stop-decision edge; busy drops on that same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p_data     <= {DATA_WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_decide && (r_state == S_STOP)) begin
        r_data_valid <= w_bit & ~r_par_bad;
        r_stp_err    <= ~w_bit;
        r_par_err    <= r_par_bad;
        if (w_bit && !r_par_bad) begin
          r_p_data <= r_shift;
        end
      end else begin
        r_data_valid <= 1'b0;
        r_stp_err    <= 1'b0;
        r_par_err    <= 1'b0;
      end
    end
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stp_err    = r_stp_err;
  assign o_rx_busy    = r_busy;

endmodule
